// File: rtl/rotor_sequencer.sv
// rtl/rotor_sequencer.sv - Enigma forward-path sequencer sharing one rotor LUT port across all rotor slots
module rotor_sequencer #(
    parameter int ALPHABET_LEN = 26,
    parameter int PORTLEN      = 5,
    parameter int NUM_ROTORS   = 3,
    parameter int NOTCH0       = 16,
    parameter int NOTCH1       = 4,
    localparam int SELW        = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PORTLEN-1:0]            in_letter,
    input  logic                          pos_load,
    input  logic [NUM_ROTORS*PORTLEN-1:0] pos_init,
    output logic [NUM_ROTORS*PORTLEN-1:0] pos_out,
    output logic [SELW-1:0]               rot_sel,
    output logic [PORTLEN-1:0]            rot_letter,
    output logic                          rot_cs_n,
    input  logic [PORTLEN-1:0]            rot_data,
    input  logic                          rot_error,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PORTLEN-1:0]            out_letter,
    output logic                          out_error
);

    typedef enum logic [1:0] {IDLE, STEP, ROT, DONE} state_t;

    localparam logic [PORTLEN:0]   ALEN   = (PORTLEN+1)'(ALPHABET_LEN);
    localparam logic [PORTLEN-1:0] LAST   = PORTLEN'(ALPHABET_LEN - 1);
    localparam logic [PORTLEN-1:0] N0     = PORTLEN'(NOTCH0);
    localparam logic [PORTLEN-1:0] N1     = PORTLEN'(NOTCH1);
    localparam logic [SELW-1:0]    K_LAST = SELW'(NUM_ROTORS - 1);

    state_t             state;
    logic [PORTLEN-1:0] pos [NUM_ROTORS];
    logic [PORTLEN-1:0] cur;
    logic [SELW-1:0]    k;
    logic               err;

    logic [PORTLEN-1:0]    pos_k;
    logic [PORTLEN:0]      addr_sum;
    logic [PORTLEN:0]      addr_full;
    logic [PORTLEN:0]      data_ext;
    logic [PORTLEN:0]      back_full;
    logic [PORTLEN-1:0]    addr;
    logic [PORTLEN-1:0]    back;
    logic                  data_bad;
    logic [NUM_ROTORS-1:0] step;

    // One position step, wrapping the last letter back to the first.
    function automatic logic [PORTLEN-1:0] inc_mod(input logic [PORTLEN-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Shared rotor datapath: offset address into the LUT, un-offset its answer, and stepping decisions.
    always_comb begin
        pos_k     = pos[k];
        addr_sum  = {1'b0, cur} + {1'b0, pos_k};
        addr_full = (addr_sum >= ALEN) ? addr_sum - ALEN : addr_sum;
        addr      = addr_full[PORTLEN-1:0];
        data_ext  = {1'b0, rot_data};
        back_full = (rot_data < pos_k) ? data_ext + ALEN - {1'b0, pos_k}
                                       : data_ext - {1'b0, pos_k};
        back      = back_full[PORTLEN-1:0];
        data_bad  = rot_error || (data_ext >= ALEN);
        step      = '0;
        step[0]   = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            if (i == 1) begin
                // Middle rotor also steps on its own notch: the double-step.
                step[i] = (pos[i-1] == N0) || (pos[i] == N1);
            end else if (i == 2) begin
                step[i] = (pos[i-1] == N1);
            end
        end
    end

    // Sequencer FSM: accept, step, walk the rotors one per cycle, hand off the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            k     <= '0;
            err   <= 1'b0;
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pos_load) begin
                        for (int i = 0; i < NUM_ROTORS; i++) begin
                            pos[i] <= ({1'b0, pos_init[i*PORTLEN +: PORTLEN]} >= ALEN)
                                      ? '0 : pos_init[i*PORTLEN +: PORTLEN];
                        end
                    end else if (in_valid) begin
                        if ({1'b0, in_letter} >= ALEN) begin
                            // Illegal letter skips the rotors and leaves positions untouched.
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= in_letter;
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    for (int i = 0; i < NUM_ROTORS; i++) begin
                        if (step[i]) begin
                            pos[i] <= inc_mod(pos[i]);
                        end
                    end
                    k     <= '0;
                    state <= ROT;
                end
                ROT: begin
                    cur <= back;
                    if (data_bad) begin
                        err <= 1'b1;
                    end
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = rst_n && (state == IDLE) && !pos_load;
    assign rot_cs_n   = (state != ROT);
    assign rot_sel    = (state == ROT) ? k : '0;
    assign rot_letter = (state == ROT) ? addr : '0;
    assign out_valid  = (state == DONE);
    assign out_letter = ((state == DONE) && !err) ? cur : '0;
    assign out_error  = (state == DONE) && err;

    genvar g;
    generate
        for (g = 0; g < NUM_ROTORS; g++) begin : g_pos
            assign pos_out[g*PORTLEN +: PORTLEN] = pos[g];
        end
    endgenerate

endmodule

// File: tb/tb_rotor_sequencer.sv
// tb/tb_rotor_sequencer.sv - randomized self-checking bench for rotor_sequencer against an arithmetic Enigma model
module tb_rotor_sequencer;

    localparam int AL = 26;
    localparam int PL = 5;
    localparam int NR = 3;
    localparam int N0 = 16;
    localparam int N1 = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PL-1:0]   in_letter = '0;
    logic            pos_load = 1'b0;
    logic [NR*PL-1:0] pos_init = '0;
    logic [NR*PL-1:0] pos_out;
    logic [1:0]      rot_sel;
    logic [PL-1:0]   rot_letter;
    logic            rot_cs_n;
    logic [PL-1:0]   rot_data;
    logic            rot_error;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PL-1:0]   out_letter;
    logic            out_error;

    logic [PL-1:0] lut [NR][32];
    int            err_rotor = -1;

    int checks = 0;
    int passed = 0;
    int mpos [NR];
    int exp_sel_q[$];
    int exp_addr_q[$];
    int exp_let_q[$];
    int exp_err_q[$];
    int obs_sel_q[$];
    int obs_let_q[$];
    bit mon_en = 1'b0;

    rotor_sequencer #(
        .ALPHABET_LEN(AL), .PORTLEN(PL), .NUM_ROTORS(NR), .NOTCH0(N0), .NOTCH1(N1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
        .pos_load(pos_load), .pos_init(pos_init), .pos_out(pos_out),
        .rot_sel(rot_sel), .rot_letter(rot_letter), .rot_cs_n(rot_cs_n),
        .rot_data(rot_data), .rot_error(rot_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_letter(out_letter), .out_error(out_error)
    );

    always #5 clk = ~clk;

    assign rot_data  = (rot_sel < 2'(NR)) ? lut[rot_sel][rot_letter] : '0;
    assign rot_error = !rot_cs_n && (int'(rot_sel) == err_rotor);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int pos_field(input int k);
        return int'(pos_out[k*PL +: PL]);
    endfunction

    task automatic flush();
        exp_sel_q.delete();
        exp_addr_q.delete();
        exp_let_q.delete();
        exp_err_q.delete();
    endtask

    // Enigma forward path in plain modular arithmetic: step, then pass through each rotor.
    task automatic predict(input int letter);
        int c, a, d, e;
        bit s1, s2;
        if (letter >= AL) begin
            exp_let_q.push_back(0);
            exp_err_q.push_back(1);
            return;
        end
        s1 = (mpos[0] == N0) || (mpos[1] == N1);
        s2 = (mpos[1] == N1);
        mpos[0] = (mpos[0] + 1) % AL;
        if (s1) mpos[1] = (mpos[1] + 1) % AL;
        if (s2) mpos[2] = (mpos[2] + 1) % AL;
        c = letter;
        e = 0;
        for (int r = 0; r < NR; r++) begin
            a = (c + mpos[r]) % AL;
            exp_sel_q.push_back(r);
            exp_addr_q.push_back(a);
            d = int'(lut[r][a]);
            if (d >= AL || r == err_rotor) e = 1;
            c = (d - mpos[r] + AL) % AL;
        end
        exp_let_q.push_back(e ? 0 : c);
        exp_err_q.push_back(e);
    endtask

    // Per-cycle compare of the rotor port and the result port against the model queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rot_cs_n) begin
                obs_sel_q.push_back(int'(rot_sel));
                obs_let_q.push_back(int'(rot_letter));
                if (exp_sel_q.size() == 0) begin
                    chk("rot_unexpected", 1, 0);
                end else begin
                    chk("rot_sel", int'(rot_sel), exp_sel_q.pop_front());
                    chk("rot_letter", int'(rot_letter), exp_addr_q.pop_front());
                end
                chk("in_ready_rot", int'(in_ready), 0);
            end else begin
                chk("rot_letter_idle", int'(rot_letter), 0);
                chk("rot_sel_idle", int'(rot_sel), 0);
            end
            if (out_valid) begin
                if (exp_let_q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    chk("out_letter", int'(out_letter), exp_let_q[0]);
                    chk("out_error", int'(out_error), exp_err_q[0]);
                    chk("in_ready_done", int'(in_ready), 0);
                    if (out_ready) begin
                        exp_let_q.delete(0);
                        exp_err_q.delete(0);
                    end
                end
            end
        end
    end

    task automatic load(input int p0, input int p1, input int p2);
        pos_init = {PL'(p2), PL'(p1), PL'(p0)};
        pos_load = 1'b1;
        @(negedge clk);
        chk("load_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        pos_load = 1'b0;
        mpos[0] = (p0 < AL) ? p0 : 0;
        mpos[1] = (p1 < AL) ? p1 : 0;
        mpos[2] = (p2 < AL) ? p2 : 0;
        @(negedge clk);
        for (int k = 0; k < NR; k++) chk("load_pos", pos_field(k), mpos[k]);
        @(posedge clk); #1;
    endtask

    task automatic send(input int letter, input int hold, input bit pulse,
                        output int wait_n, output int got_l, output int got_e);
        bit seen;
        int cyc;
        wait_n = 0;
        got_l = -1;
        got_e = -1;
        predict(letter);
        in_valid = 1'b1;
        in_letter = PL'(letter);
        seen = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            seen = in_ready;
            wait_n = i;
            @(posedge clk); #1;
            if (seen) break;
        end
        in_valid = 1'b0;
        if (!seen) begin
            chk("accept_timeout", 0, 1);
            flush();
            return;
        end
        seen = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                cyc = i;
                break;
            end
            @(posedge clk); #1;
            pos_load = pulse && (i == 1);
            if (pos_load) pos_init = (NR*PL)'($urandom);
        end
        pos_load = 1'b0;
        if (!seen) begin
            chk("out_timeout", 0, 1);
            flush();
            return;
        end
        chk("latency", cyc, (letter >= AL) ? 1 : NR + 2);
        got_l = int'(out_letter);
        got_e = int'(out_error);
        for (int k = 0; k < NR; k++) chk("pos_after", pos_field(k), mpos[k]);
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int w, gl, ge, letter;
        int t2_let [3] = '{1, 1, 2};

        for (int r = 0; r < NR; r++)
            for (int a = 0; a < 32; a++) lut[r][a] = PL'((a + 1) % AL);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_letter", int'(out_letter), 0);
        chk("rst_out_error", int'(out_error), 0);
        chk("rst_cs_n", int'(rot_cs_n), 1);
        chk("rst_rot_sel", int'(rot_sel), 0);
        chk("rst_rot_letter", int'(rot_letter), 0);
        chk("rst_pos", int'(pos_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_cs_n", int'(rot_cs_n), 1);
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) mpos[k] = 0;
        mon_en = 1'b1;

        // Literal walk-through with every LUT = addr+1
        obs_sel_q.delete();
        obs_let_q.delete();
        send(0, 0, 1'b0, w, gl, ge);
        chk("t2_letter", gl, 3);
        chk("t2_error", ge, 0);
        chk("t2_p0", pos_field(0), 1);
        chk("t2_p1", pos_field(1), 0);
        chk("t2_p2", pos_field(2), 0);
        chk("t2_rot_count", obs_let_q.size(), 3);
        for (int i = 0; i < obs_let_q.size() && i < 3; i++) begin
            chk("t2_rot_sel_seq", obs_sel_q[i], i);
            chk("t2_rot_let_seq", obs_let_q[i], t2_let[i]);
        end

        // Stepping corner cases
        load(16, 0, 0);
        send(int'($urandom_range(25)), 0, 1'b0, w, gl, ge);
        chk("t3a_p0", pos_field(0), 17);
        chk("t3a_p1", pos_field(1), 1);
        chk("t3a_p2", pos_field(2), 0);
        load(5, 4, 0);
        send(int'($urandom_range(25)), 0, 1'b0, w, gl, ge);
        chk("t3b_p0", pos_field(0), 6);
        chk("t3b_p1", pos_field(1), 5);
        chk("t3b_p2", pos_field(2), 1);
        load(25, 25, 25);
        send(int'($urandom_range(25)), 0, 1'b0, w, gl, ge);
        chk("t3c_p0", pos_field(0), 0);
        chk("t3c_p1", pos_field(1), 25);
        chk("t3c_p2", pos_field(2), 25);

        // Illegal letter and rotor error
        send(27, 0, 1'b0, w, gl, ge);
        chk("t4_ill_letter", gl, 0);
        chk("t4_ill_error", ge, 1);
        chk("t4_ill_p0", pos_field(0), 0);
        chk("t4_ill_p1", pos_field(1), 25);
        chk("t4_ill_p2", pos_field(2), 25);
        err_rotor = 1;
        send(7, 0, 1'b0, w, gl, ge);
        chk("t4_roterr_error", ge, 1);
        chk("t4_roterr_letter", gl, 0);
        err_rotor = -1;

        // Back-pressure in DONE and pos_load during ROT
        send(5, 3, 1'b1, w, gl, ge);

        // Load colliding with a letter: load wins, letter follows next cycle
        in_valid = 1'b1;
        in_letter = PL'(11);
        pos_init = {PL'(2), PL'(3), PL'(9)};
        pos_load = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        pos_load = 1'b0;
        mpos[0] = 9; mpos[1] = 3; mpos[2] = 2;
        send(11, 0, 1'b0, w, gl, ge);
        chk("t6_accept_wait", w, 1);
        chk("t6_p0", pos_field(0), 10);

        // Reset in the middle of ROT aborts the letter
        mon_en = 1'b0;
        in_valid = 1'b1;
        in_letter = PL'(4);
        @(negedge clk);
        chk("t1_accept_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_in_rot", int'(rot_cs_n), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t1_rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_rst_out_valid", int'(out_valid), 0);
        chk("t1_rst_cs_n", int'(rot_cs_n), 1);
        chk("t1_rst_pos", int'(pos_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t1_post_out_valid", int'(out_valid), 0);
            chk("t1_post_in_ready", int'(in_ready), 1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < NR; k++) mpos[k] = 0;
        flush();
        mon_en = 1'b1;

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 0) begin
                for (int r = 0; r < NR; r++)
                    for (int a = 0; a < 32; a++)
                        lut[r][a] = ($urandom_range(15) == 0) ? PL'($urandom_range(31, 26))
                                                              : PL'($urandom_range(25));
            end
            if ($urandom_range(3) == 0)
                load(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)));
            err_rotor = ($urandom_range(7) == 0) ? int'($urandom_range(2)) : -1;
            letter = ($urandom_range(9) == 0) ? int'($urandom_range(31, 26)) : int'($urandom_range(25));
            send(letter, int'($urandom_range(2)), 1'($urandom_range(1)), w, gl, ge);
        end
        err_rotor = -1;
        repeat (3) @(posedge clk);
        chk("end_queues_empty", exp_let_q.size() + exp_sel_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
